// File: rtl/cp0_exception_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : cp0_exception_unit_if
// Brief    : Pipeline/M-stage and mfc0/mtc0 bus bundle for the CP0 exception unit
// Revision : 1.0 - initial release
// ============================================================================
interface cp0_exception_unit_if #(
  parameter int HWINT_W = 6
);
  logic [31:0]        pc_m;
  logic               bd_m;
  logic [4:0]         exc_code_m;
  logic [HWINT_W-1:0] hw_int;
  logic               we;
  logic [4:0]         addr;
  logic [31:0]        din;
  logic               eret;
  logic [31:0]        dout;
  logic [31:0]        epc_out;
  logic               req;

  modport master (
    output pc_m, bd_m, exc_code_m, hw_int, we, addr, din, eret,
    input  dout, epc_out, req
  );

  modport slave (
    input  pc_m, bd_m, exc_code_m, hw_int, we, addr, din, eret,
    output dout, epc_out, req
  );
endinterface
`default_nettype wire

// File: rtl/cp0_exception_unit.sv
`default_nettype none
// ============================================================================
// Module   : cp0_exception_unit
// Brief    : CP0 SR/Cause/EPC/PRId, interrupt/exception decision at M/W
// Revision : 1.0 - initial release
// ============================================================================
module cp0_exception_unit #(
  parameter logic [31:0] PRID_VALUE = 32'h0000_7A07,
  parameter int          HWINT_W    = 6
) (
  input  wire                   clk,
  input  wire                   reset,
  cp0_exception_unit_if.slave   bus
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [HWINT_W-1:0] im;
  logic               exl;
  logic               ie;
  logic               bd;
  logic [HWINT_W-1:0] ip;
  logic [4:0]         exc_code;
  logic [31:2]        epc;

  logic               int_req;
  logic               exc_req;
  logic               req;
  logic [31:2]        epc_target;
  logic               sr_write;
  logic               epc_write;

  // Raw pins feed the interrupt decision; IP is only the registered view.
  assign int_req = (|(bus.hw_int & im)) & ie & ~exl;
  assign exc_req = (bus.exc_code_m != 5'd0) & ~exl;
  assign req     = int_req | exc_req;

  // pc-4 never touches bits [1:0], so the word address is decremented directly.
  assign epc_target = bus.bd_m ? (bus.pc_m[31:2] - 30'd1) : bus.pc_m[31:2];

  assign sr_write  = bus.we && (bus.addr == ADDR_SR);
  assign epc_write = bus.we && (bus.addr == ADDR_EPC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= 5'd0;
      epc      <= 30'd0;
    end else begin
      ip <= bus.hw_int;
      if (req) begin
        // Taking the trap discards any mtc0 or eret issued in the same cycle.
        exl      <= 1'b1;
        bd       <= bus.bd_m;
        exc_code <= int_req ? 5'd0 : bus.exc_code_m;
        epc      <= epc_target;
      end else begin
        if (sr_write) begin
          im  <= bus.din[10 +: HWINT_W];
          exl <= bus.din[1];
          ie  <= bus.din[0];
        end
        if (epc_write) begin
          epc <= bus.din[31:2];
        end
        if (bus.eret) begin
          exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    bus.dout = 32'd0;
    case (bus.addr)
      ADDR_SR: begin
        bus.dout[10 +: HWINT_W] = im;
        bus.dout[1]             = exl;
        bus.dout[0]             = ie;
      end
      ADDR_CAUSE: begin
        bus.dout[31]            = bd;
        bus.dout[10 +: HWINT_W] = ip;
        bus.dout[6:2]           = exc_code;
      end
      ADDR_EPC:  bus.dout = {epc, 2'b00};
      ADDR_PRID: bus.dout = PRID_VALUE;
      default:   bus.dout = 32'd0;
    endcase
  end

  assign bus.epc_out = {epc, 2'b00};
  assign bus.req     = req;

  logic unused_bits;
  assign unused_bits = ^{bus.din[31:16], bus.din[9:2], bus.pc_m[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_cp0_exception_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_exception_unit
// Brief    : Directed + random bench against a register-level CP0 model
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_exception_unit;

  localparam logic [31:0] PRID = 32'h0000_7A07;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  // Architectural model: whole 32-bit register images
  logic [31:0] m_sr, m_cause, m_epc;

  cp0_exception_unit_if #(.HWINT_W(6)) bus ();

  cp0_exception_unit #(.PRID_VALUE(PRID), .HWINT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic m_int();
    return ((bus.hw_int & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return m_int() || ((bus.exc_code_m != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_dout(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_update();
    logic [31:0] target;
    logic [31:0] ipv;
    ipv = {16'd0, bus.hw_int, 10'd0};
    if (m_req()) begin
      target  = bus.bd_m ? bus.pc_m - 32'd4 : bus.pc_m;
      m_epc   = target & 32'hFFFF_FFFC;
      m_cause = {bus.bd_m, 31'd0} | ipv | ((m_int() ? 32'd0 : 32'(bus.exc_code_m)) << 2);
      m_sr    = m_sr | 32'd2;
    end else begin
      m_cause = (m_cause & ~32'h0000_FC00) | ipv;
      if (bus.we && bus.addr == 5'd12) m_sr  = bus.din & 32'h0000_FC03;
      if (bus.we && bus.addr == 5'd14) m_epc = bus.din & 32'hFFFF_FFFC;
      if (bus.eret) m_sr = m_sr & ~32'd2;
    end
  endtask

  task automatic idle();
    bus.pc_m = 32'd0; bus.bd_m = 1'b0; bus.exc_code_m = 5'd0; bus.hw_int = 6'd0;
    bus.we = 1'b0; bus.addr = 5'd0; bus.din = 32'd0; bus.eret = 1'b0;
  endtask

  // Called at a negedge with inputs set: check vs model, cross one edge.
  task automatic step();
    #1;
    check("req", 32'(bus.req), 32'(m_req()));
    check("dout", bus.dout, m_dout(bus.addr));
    check("epc_out", bus.epc_out, m_epc);
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
    bus.addr = a;
    #1;
    check(tag, bus.dout, exp);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    m_sr = 0; m_cause = 0; m_epc = 0;
    reset = 1'b0;
    idle();
    @(negedge clk);
    #1 check("rst_req", 32'(bus.req), 32'd0);
    rd(5'd12, "rst_sr", 32'd0);
    rd(5'd13, "rst_cause", 32'd0);
    rd(5'd15, "rst_prid", PRID);
    @(negedge clk);
    reset = 1'b1;
    idle();

    // Interrupt
    bus.we = 1'b1; bus.addr = 5'd12; bus.din = 32'h0000_0401;
    step();
    idle(); bus.pc_m = 32'h3008; bus.hw_int = 6'd1;
    #1 check("t2_req", 32'(bus.req), 32'd1);
    step();
    rd(5'd13, "t2_cause", 32'h0000_0400);
    rd(5'd12, "t2_sr", 32'h0000_0403);
    check("t2_epc", bus.epc_out, 32'h3008);
    check("t2_req_masked", 32'(bus.req), 32'd0);
    step();

    // eret
    idle(); bus.eret = 1'b1;
    check("t5_epc_during", bus.epc_out, 32'h3008);
    step();
    idle();
    rd(5'd12, "t5_sr", 32'h0000_0401);
    check("t5_epc_after", bus.epc_out, 32'h3008);

    // Exception in delay slot
    bus.bd_m = 1'b1; bus.exc_code_m = 5'd12; bus.pc_m = 32'h3004;
    #1 check("t3_req", 32'(bus.req), 32'd1);
    step();
    idle();
    rd(5'd13, "t3_cause", 32'h8000_0030);
    check("t3_epc", bus.epc_out, 32'h3000);
    bus.eret = 1'b1;
    step();

    // Interrupt beats exception
    idle(); bus.hw_int = 6'd1; bus.exc_code_m = 5'd10;
    step();
    idle();
    rd(5'd13, "t4_prio", 32'h0000_0400);
    bus.eret = 1'b1;
    step();

    // IE=0: exception alone
    idle(); bus.we = 1'b1; bus.addr = 5'd12; bus.din = 32'h0000_0400;
    step();
    idle(); bus.hw_int = 6'd1; bus.exc_code_m = 5'd10;
    #1 check("t4_ie0_req", 32'(bus.req), 32'd1);
    step();
    idle();
    rd(5'd13, "t4_ie0_cause", 32'h0000_0428);

    // EXL masks everything
    bus.exc_code_m = 5'd10; bus.pc_m = 32'h7770;
    #1 check("t4_exl_req", 32'(bus.req), 32'd0);
    step();
    idle();
    check("t4_exl_epc", bus.epc_out, 32'd0);
    rd(5'd13, "t4_exl_cause", 32'h0000_0028);

    // Write suppression
    bus.eret = 1'b1;
    step();
    idle(); bus.we = 1'b1; bus.addr = 5'd14; bus.din = 32'h1235;
    step();
    idle();
    rd(5'd14, "t6_epc_wr", 32'h1234);
    bus.we = 1'b1; bus.addr = 5'd14; bus.din = 32'h5000;
    bus.exc_code_m = 5'd4; bus.pc_m = 32'h3020;
    step();
    idle();
    check("t6_epc_sup", bus.epc_out, 32'h3020);

    // Mid-run asynchronous reset with EXL=1, EPC=0x3010
    bus.eret = 1'b1;
    step();
    idle(); bus.exc_code_m = 5'd4; bus.pc_m = 32'h3010;
    step();
    idle();
    check("t1_pre_epc", bus.epc_out, 32'h3010);
    #2 reset = 1'b0;
    m_sr = 0; m_cause = 0; m_epc = 0;
    #1 check("t1_req", 32'(bus.req), 32'd0);
    check("t1_epc", bus.epc_out, 32'd0);
    rd(5'd12, "t1_sr", 32'd0);
    rd(5'd13, "t1_cause", 32'd0);
    rd(5'd15, "t1_prid", PRID);
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.pc_m       = $urandom;
      bus.bd_m       = 1'($urandom);
      bus.exc_code_m = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'd0;
      bus.hw_int     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      bus.we         = ($urandom_range(0, 3) == 0);
      bus.addr       = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
      bus.din        = $urandom;
      bus.eret       = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
